mdu_ctrl: RTL and testbench



---
 rtl/mdu_pkg.sv | 16 +
 rtl/mdu_shift_add.sv | 24 ++
 rtl/mdu_ctrl.sv | 81 ++++++++
 tb/tb_mdu_ctrl.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - shared types and constants for the HI/LO multiply unit
package mdu_pkg;

  localparam int MDU_WIDTH = 32;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01
  } mdu_state_t;

  // Iteration counter needs to hold WIDTH-1; keep at least one bit for tiny widths.
  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/mdu_shift_add.sv
// rtl/mdu_shift_add.sv - one radix-2 shift-add multiply iteration
module mdu_shift_add #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] mplier,
  input  logic [WIDTH-1:0] mcand,
  output logic [WIDTH-1:0] acc_next,
  output logic [WIDTH-1:0] mplier_next
);

  logic [WIDTH:0] sum;

  always_comb begin
    sum = {1'b0, acc};
    if (mplier[0]) begin
      sum = {1'b0, acc} + {1'b0, mcand};
    end
    // {carry, acc, mplier} >> 1: the low sum bit moves into the multiplier's top bit
    acc_next    = sum[WIDTH:1];
    mplier_next = {sum[0], mplier[WIDTH-1:1]};
  end

endmodule

// File: rtl/mdu_ctrl.sv
// rtl/mdu_ctrl.sv - MULTU sequencer owning HI/LO, with hazard stall generation
module mdu_ctrl
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             rd_req,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = cnt_width(WIDTH);

  mdu_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc_next;
  logic [WIDTH-1:0] mplier_next;

  mdu_shift_add #(.WIDTH(WIDTH)) u_shift_add (
    .acc         (acc),
    .mplier      (mplier),
    .mcand       (mcand),
    .acc_next    (acc_next),
    .mplier_next (mplier_next)
  );

  assign busy  = (state == S_RUN);
  // A start or read arriving mid-multiply must wait; the done cycle is already IDLE.
  assign stall = busy & (rd_req | start);

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      cnt    <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      hi     <= '0;
      lo     <= '0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            mcand  <= a;
            mplier <= b;
            acc    <= '0;
            cnt    <= CNT_W'(WIDTH - 1);
            state  <= S_RUN;
          end
        end
        S_RUN: begin
          acc    <= acc_next;
          mplier <= mplier_next;
          cnt    <= cnt - CNT_W'(1);
          // HI/LO only ever receive the finished product.
          if (cnt == '0) begin
            hi    <= acc_next;
            lo    <= mplier_next;
            done  <= 1'b1;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_ctrl.sv
// tb/tb_mdu_ctrl.sv - directed self-checking bench for mdu_ctrl
module tb_mdu_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        rd_req;
  logic        busy;
  logic        stall;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_checks = 0;
  int n_fail   = 0;
  int hold_bad = 0;

  mdu_ctrl #(.WIDTH(32)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .a      (a),
    .b      (b),
    .rd_req (rd_req),
    .busy   (busy),
    .stall  (stall),
    .done   (done),
    .hi     (hi),
    .lo     (lo)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Ticks until done is seen (bounded); flags any HI/LO change before completion.
  task automatic wait_done(output int n);
    logic [31:0] hi0, lo0;
    hi0 = hi;
    lo0 = lo;
    n = 0;
    while (!done && n < 40) begin
      tick();
      n++;
      if (!done && (hi !== hi0 || lo !== lo0)) hold_bad++;
    end
  endtask

  task automatic run_op(input string tag, input logic [31:0] av, input logic [31:0] bv,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int n;
    a = av; b = bv; start = 1'b1;
    tick();
    start = 1'b0;
    chk({tag, "_busy"}, 64'(busy), 64'd1);
    wait_done(n);
    chk({tag, "_latency"}, 64'(n), 64'd32);
    chk({tag, "_hi"}, 64'(hi), 64'(exp_hi));
    chk({tag, "_lo"}, 64'(lo), 64'(exp_lo));
    chk({tag, "_idle_at_done"}, 64'(busy), 64'd0);
    tick();
    chk({tag, "_done_one_pulse"}, 64'(done), 64'd0);
  endtask

  initial begin
    int n;
    int stall_low;
    int done_seen;
    rst = 1'b1; start = 1'b0; a = '0; b = '0; rd_req = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_hi", 64'(hi), 64'd0);
    chk("reset_lo", 64'(lo), 64'd0);
    rd_req = 1'b1;
    #1;
    chk("idle_rd_no_stall", 64'(stall), 64'd0);
    rd_req = 1'b0;

    run_op("m3x5", 32'd3, 32'd5, 32'h0, 32'hF);
    run_op("mffxff", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h1);
    run_op("m0", 32'h0, 32'h1234_5678, 32'h0, 32'h0);

    // MFHI/MFLO held off by an in-flight multiply.
    a = 32'h1_0000; b = 32'h1_0000; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    rd_req = 1'b1;
    #1;
    n = 1;
    stall_low = 0;
    while (!done && n < 40) begin
      if (busy && !stall) stall_low++;
      tick();
      n++;
    end
    chk("rd_stall_held", 64'(stall_low), 64'd0);
    chk("rd_latency", 64'(n), 64'd32);
    chk("rd_stall_drop", 64'(stall), 64'd0);
    chk("rd_hi", 64'(hi), 64'd1);
    chk("rd_lo", 64'(lo), 64'd0);
    rd_req = 1'b0;
    tick();

    // Second MULTU arrives at cycle 5 and waits for the first to finish.
    a = 32'd3; b = 32'd4; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    a = 32'd7; b = 32'd6; start = 1'b1;
    #1;
    chk("st2_stall", 64'(stall), 64'd1);
    n = 5;
    stall_low = 0;
    while (!done && n < 40) begin
      if (busy && !stall) stall_low++;
      tick();
      n++;
    end
    chk("st2_stall_held", 64'(stall_low), 64'd0);
    chk("st2_first_lo", 64'(lo), 64'd12);
    chk("st2_done_no_stall", 64'(stall), 64'd0);
    tick();
    start = 1'b0;
    chk("st2_accepted", 64'(busy), 64'd1);
    wait_done(n);
    chk("st2_latency", 64'(n), 64'd32);
    chk("st2_hi", 64'(hi), 64'd0);
    chk("st2_lo", 64'(lo), 64'h2A);
    tick();

    // Reset mid-RUN aborts without a done pulse.
    a = 32'd9; b = 32'd9; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (9) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_hi", 64'(hi), 64'd0);
    chk("abort_lo", 64'(lo), 64'd0);
    done_seen = 0;
    repeat (40) begin
      if (done) done_seen++;
      tick();
    end
    chk("abort_no_done", 64'(done_seen), 64'd0);
    run_op("m2x2", 32'd2, 32'd2, 32'h0, 32'h4);

    // Back-to-back: next MULTU issued in the done cycle.
    a = 32'h100; b = 32'h100; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(n);
    chk("b2b_first_lo", 64'(lo), 64'h1_0000);
    a = 32'h1234_5678; b = 32'h10; start = 1'b1;
    #1;
    chk("b2b_no_stall", 64'(stall), 64'd0);
    tick();
    start = 1'b0;
    chk("b2b_accepted", 64'(busy), 64'd1);
    wait_done(n);
    chk("b2b_latency", 64'(n), 64'd32);
    chk("b2b_hi", 64'(hi), 64'h1);
    chk("b2b_lo", 64'(lo), 64'h2345_6780);

    chk("hilo_hold", 64'(hold_bad), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
